// File: rtl/h75_pixel_loader_if.sv
// h75_pixel_loader_if: pixel stream (valid/ready + sof) and framebuffer write port
interface h75_pixel_loader_if #(parameter int ADDR_W = 15);
    logic              s_valid;
    logic              s_ready;
    logic [23:0]       s_data;
    logic              s_sof;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
    modport master (output s_valid, s_data, s_sof, input s_ready, wr_en, wr_addr, wr_data);
    modport slave  (input s_valid, s_data, s_sof, output s_ready, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/h75_pixel_loader.sv
// h75_pixel_loader: RGB888 raster stream to RGB565 framebuffer writes with frame tracking
module h75_pixel_loader #(
    parameter int ADDR_W    = 15,
    parameter int MAX_WORDS = 32768
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                enable,
    input  logic [9:0]          pixels_per_row,
    input  logic [6:0]          num_rows,
    h75_pixel_loader_if.slave   bus,
    output logic                frame_done,
    output logic                busy,
    output logic                sof_err,
    output logic                cfg_err
);
    typedef enum logic [1:0] {IDLE, WAIT_SOF, RUN} state_t;
    state_t state_q, state_d;
    logic [9:0] col_q, col_d, ppr_q, ppr_d, cur_ppr, cur_col;
    logic [6:0] row_q, row_d, rows_q, rows_d, cur_rows, cur_row;
    logic [ADDR_W-1:0] base_q, base_d, cur_base, wr_addr_q, wr_addr_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic wr_en_q, wr_en_d, last_q, last_d, frame_done_q;
    logic sof_err_q, sof_err_d, cfg_err_q, cfg_err_d;
    logic xfer, sof, bad, last_col, last;
    logic [16:0] prod;

    assign bus.s_ready = enable & (state_q != IDLE);
    assign xfer        = bus.s_valid & bus.s_ready;
    assign sof         = xfer & bus.s_sof;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign frame_done  = frame_done_q;
    assign busy        = state_q == RUN;
    assign sof_err     = sof_err_q;
    assign cfg_err     = cfg_err_q;

    always_comb begin
        // A sof pixel restarts position and geometry, so it is handled as pixel (0,0) of a new frame
        cur_ppr   = sof ? pixels_per_row : ppr_q;
        cur_rows  = sof ? num_rows : rows_q;
        cur_col   = sof ? '0 : col_q;
        cur_row   = sof ? '0 : row_q;
        cur_base  = sof ? '0 : base_q;
        prod      = 17'(pixels_per_row) * 17'(num_rows);
        bad       = (pixels_per_row == '0) | (num_rows == '0) | (prod > 17'(MAX_WORDS));
        last_col  = cur_col == cur_ppr - 10'd1;
        last      = last_col & (cur_row == cur_rows - 7'd1);
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        base_d    = base_q;
        ppr_d     = ppr_q;
        rows_d    = rows_q;
        wr_en_d   = 1'b0;
        last_d    = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        sof_err_d = sof_err_q | (sof & (state_q == RUN));
        cfg_err_d = cfg_err_q | (sof & bad);
        if (!enable) begin
            state_d = IDLE;
            col_d   = '0;
            row_d   = '0;
            base_d  = '0;
        end else if (state_q == IDLE) begin
            state_d = WAIT_SOF;
        end else if (sof & bad) begin
            state_d = WAIT_SOF;
            col_d   = '0;
            row_d   = '0;
            base_d  = '0;
        end else if (xfer & (sof | (state_q == RUN))) begin
            wr_en_d   = 1'b1;
            last_d    = last;
            wr_addr_d = cur_base + ADDR_W'(cur_col);
            wr_data_d = {bus.s_data[23:19], bus.s_data[15:10], bus.s_data[7:3]};
            ppr_d     = cur_ppr;
            rows_d    = cur_rows;
            state_d   = last ? WAIT_SOF : RUN;
            col_d     = last_col ? '0 : cur_col + 10'd1;
            row_d     = last ? '0 : (last_col ? cur_row + 7'd1 : cur_row);
            base_d    = last ? '0 : (last_col ? cur_base + ADDR_W'(cur_ppr) : cur_base);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            base_q       <= '0;
            ppr_q        <= '0;
            rows_q       <= '0;
            wr_en_q      <= 1'b0;
            last_q       <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            sof_err_q    <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            base_q       <= base_d;
            ppr_q        <= ppr_d;
            rows_q       <= rows_d;
            wr_en_q      <= wr_en_d;
            last_q       <= last_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= last_q;
            sof_err_q    <= sof_err_d;
            cfg_err_q    <= cfg_err_d;
        end
    end
endmodule

// File: tb/tb_h75_pixel_loader.sv
// tb_h75_pixel_loader: table-driven frames plus hand sequences, scoreboarded write port
module tb_h75_pixel_loader;
    logic clk = 1'b0, resetn = 1'b0, enable = 1'b0;
    logic [9:0] ppr = '0;
    logic [6:0] rows = '0;
    logic frame_done, busy, sof_err, cfg_err;

    always #10 clk = ~clk;

    h75_pixel_loader_if ifc ();
    h75_pixel_loader dut (
        .clk(clk), .resetn(resetn), .enable(enable),
        .pixels_per_row(ppr), .num_rows(rows), .bus(ifc.slave),
        .frame_done(frame_done), .busy(busy), .sof_err(sof_err), .cfg_err(cfg_err)
    );

    typedef struct {logic [14:0] addr; logic [15:0] data; bit last; int cyc;} exp_t;
    typedef struct {int ppr; int rows; bit gaps; bit cfg; int done;} vec_t;
    exp_t q[$];
    exp_t e;
    vec_t tbl[8];
    int nvec = 0, nerr = 0, cyc = 0, ndone = 0, nwr = 0, npush = 0, d0;
    bit exp_done = 1'b0, exp_cfg = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] rgb565(input logic [23:0] p);
        return {p[23:19], p[15:10], p[7:3]};
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (!resetn) exp_done = 1'b0;
        else begin
            if (frame_done !== exp_done) begin
                nvec++; nerr++;
                $display("FAIL frame_done: got %0b, expected %0b (t=%0t)", frame_done, exp_done, $time);
            end else if (exp_done) nvec++;
            if (frame_done) ndone++;
            exp_done = 1'b0;
            if (ifc.wr_en) begin
                nwr++;
                if (q.size() == 0) check("unexpected_write", 32'(ifc.wr_addr), 32'hFFFF_FFFF);
                else begin
                    e = q.pop_front();
                    check("wr_addr", 32'(ifc.wr_addr), 32'(e.addr));
                    check("wr_data", 32'(ifc.wr_data), 32'(e.data));
                    check("wr_latency", cyc, e.cyc);
                    exp_done = e.last;
                end
            end
        end
    end

    task automatic idle(input int n);
        ifc.s_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_pix(input logic [23:0] d, input bit s, input bit push, input int addr,
                            input logic [15:0] ed, input bit last);
        int t = 0;
        ifc.s_valid = 1'b1; ifc.s_data = d; ifc.s_sof = s;
        @(negedge clk);
        while (!ifc.s_ready && t < 100) begin @(negedge clk); t++; end
        if (!ifc.s_ready) begin
            check("handshake_timeout", 32'd1, 32'd0);
            ifc.s_valid = 1'b0; ifc.s_sof = 1'b0;
            return;
        end
        @(posedge clk); #1;
        if (push) begin q.push_back('{15'(addr), ed, last, cyc}); npush++; end
        ifc.s_valid = 1'b0; ifc.s_sof = 1'b0;
    endtask

    task automatic send_frame(input int p, input int r, input bit gaps, input bit fixed);
        logic [23:0] d;
        for (int i = 0; i < p * r; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            d = fixed ? 24'hFF8040 : 24'($urandom);
            send_pix(d, i == 0, 1'b1, i, fixed ? 16'hFC08 : rgb565(d), i == p * r - 1);
        end
    endtask

    initial begin
        logic [23:0] d;
        ifc.s_valid = 1'b0; ifc.s_data = '0; ifc.s_sof = 1'b0;
        tbl = '{'{4, 2, 1'b0, 1'b0, 1}, '{64, 32, 1'b1, 1'b0, 1}, '{1, 1, 1'b0, 1'b0, 1},
                '{512, 64, 1'b0, 1'b0, 1}, '{1023, 64, 1'b0, 1'b1, 0}, '{0, 5, 1'b0, 1'b1, 0},
                '{513, 64, 1'b0, 1'b1, 0}, '{3, 0, 1'b0, 1'b1, 0}};
        #25;
        check("rst_wr_en", 32'(ifc.wr_en), 0);
        check("rst_wr_addr", 32'(ifc.wr_addr), 0);
        check("rst_wr_data", 32'(ifc.wr_data), 0);
        check("rst_s_ready", 32'(ifc.s_ready), 0);
        check("rst_flags", {frame_done, busy, sof_err, cfg_err}, 0);
        @(negedge clk); resetn = 1'b1; enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ppr = 10'(tbl[i].ppr); rows = 7'(tbl[i].rows); d0 = ndone;
            if (tbl[i].cfg) begin
                for (int k = 0; k < 3; k++) send_pix(24'($urandom), k == 0, 1'b0, 0, 16'h0, 1'b0);
                exp_cfg = 1'b1;
            end else send_frame(tbl[i].ppr, tbl[i].rows, tbl[i].gaps, i == 0);
            idle(4);
            check($sformatf("v%0d_done", i), ndone - d0, tbl[i].done);
            check($sformatf("v%0d_cfg_err", i), 32'(cfg_err), 32'(exp_cfg));
            check($sformatf("v%0d_idle", i), {busy, ifc.s_ready}, 2'b01);
            check($sformatf("v%0d_q_empty", i), q.size(), 0);
        end
        // discard before sof
        ppr = 10'd2; rows = 7'd1; d0 = ndone;
        for (int k = 0; k < 3; k++) send_pix(24'($urandom), 1'b0, 1'b0, 0, 16'h0, 1'b0);
        send_frame(2, 1, 1'b0, 1'b0);
        idle(4);
        check("nosof_done", ndone - d0, 1);
        check("nosof_sof_err", 32'(sof_err), 0);
        // sof on the 5th pixel abandons the first frame
        ppr = 10'd4; rows = 7'd4; d0 = ndone;
        for (int k = 0; k < 4; k++) begin
            d = 24'($urandom);
            send_pix(d, k == 0, 1'b1, k, rgb565(d), 1'b0);
        end
        send_frame(4, 4, 1'b0, 1'b0);
        idle(4);
        check("midsof_sof_err", 32'(sof_err), 1);
        check("midsof_done", ndone - d0, 1);
        // enable dropped at pixel 6
        ppr = 10'd4; rows = 7'd2; d0 = ndone;
        for (int k = 0; k < 6; k++) begin
            d = 24'($urandom);
            send_pix(d, k == 0, 1'b1, k, rgb565(d), 1'b0);
        end
        enable = 1'b0;
        idle(3);
        check("en_low_busy", 32'(busy), 0);
        check("en_low_s_ready", 32'(ifc.s_ready), 0);
        check("en_low_done", ndone - d0, 0);
        enable = 1'b1; d0 = ndone;
        send_frame(4, 2, 1'b0, 1'b0);
        idle(4);
        check("en_restart_done", ndone - d0, 1);
        // async reset at pixel 6: that pixel's write never appears
        d0 = ndone;
        for (int k = 0; k < 6; k++) begin
            d = 24'($urandom);
            send_pix(d, k == 0, k < 5, k, rgb565(d), 1'b0);
        end
        resetn = 1'b0; exp_cfg = 1'b0;
        #1;
        check("arst_wr_en", 32'(ifc.wr_en), 0);
        check("arst_wr_addr", 32'(ifc.wr_addr), 0);
        check("arst_s_ready", 32'(ifc.s_ready), 0);
        check("arst_flags", {frame_done, busy, sof_err, cfg_err}, 0);
        idle(2);
        check("arst_done", ndone - d0, 0);
        @(negedge clk); resetn = 1'b1; d0 = ndone;
        send_frame(4, 2, 1'b1, 1'b0);
        idle(4);
        check("arst_restart_done", ndone - d0, 1);
        check("final_writes", nwr, npush);
        check("final_q_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
